// File: rtl/dispatch_scheduler.sv
// In-order dual-issue dispatch queue: buffers fetched pairs and issues up to two per cycle.
// Optional intra-pair RAW suppression of slot 2 is enabled by defining PAIR_RAW_CHECK_EN.
module dispatch_scheduler #(
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      in_instr1,
   input  logic [31:0]      in_instr2,
   input  logic             in_valid1,
   input  logic             in_valid2,
   output logic             in_ready,
   input  logic [1:0]       be_slots,
   input  logic             serial_done,
   input  logic             flush,
   output logic [31:0]      instruction1,
   output logic [31:0]      instruction2,
   output logic             ins1_valid,
   output logic             ins2_valid,
   output logic [CNT_W-1:0] occupancy,
   output logic             dbg_state_o
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic {
      ST_RUN         = 1'b0,
      ST_WAIT_SERIAL = 1'b1
   } state_t;

   state_t           state_q;
   logic [PTR_W-1:0] head_q, tail_q;
   logic [PTR_W-1:0] head_p1, tail_p1;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      mem_q [DEPTH];
   logic [31:0]      head_w, next_w;
   logic             n1, n2, hazard;
   logic             enq1, enq2;
   logic [1:0]       enq_n, deq_n;

   function automatic logic is_serial(input logic [31:0] w);
      return (w[6:0] == 7'b1110011) || (w[6:0] == 7'b0001111);
   endfunction

   // Pointers are PTR_W wide so increments wrap modulo DEPTH for free.
   assign head_p1 = head_q + PTR_W'(1);
   assign tail_p1 = tail_q + PTR_W'(1);
   assign head_w  = mem_q[head_q];
   assign next_w  = mem_q[head_p1];

`ifdef PAIR_RAW_CHECK_EN
   logic writes_rd;
   assign writes_rd = (head_w[11:7] != 5'd0) && (head_w[6:0] != 7'b0100011)
                      && (head_w[6:0] != 7'b1100011);
   assign hazard    = writes_rd && ((head_w[11:7] == next_w[19:15])
                                    || (head_w[11:7] == next_w[24:20]));
`else
   assign hazard = 1'b0;
`endif

   assign in_ready = (count_q <= CNT_W'(DEPTH - 2));

   // be_slots==3 behaves as 2, so bit 1 alone means "two slots free".
   assign n1 = !flush && (state_q == ST_RUN) && (count_q != '0) && (be_slots != 2'd0);
   assign n2 = n1 && (count_q >= CNT_W'(2)) && be_slots[1] && !is_serial(head_w)
               && !is_serial(next_w) && !hazard;

   assign ins1_valid   = n1;
   assign ins2_valid   = n2;
   assign instruction1 = n1 ? head_w : 32'h0;
   assign instruction2 = n2 ? next_w : 32'h0;
   assign occupancy    = count_q;
   assign dbg_state_o  = (state_q == ST_WAIT_SERIAL);

   assign enq1  = in_ready && in_valid1 && !flush;
   assign enq2  = enq1 && in_valid2;
   assign enq_n = {1'b0, enq1} + {1'b0, enq2};
   assign deq_n = {1'b0, n1} + {1'b0, n2};

   assign count_d = count_q + CNT_W'(enq_n) - CNT_W'(deq_n);

   always_ff @(posedge clk) begin
      if (enq1) mem_q[tail_q]  <= in_instr1;
      if (enq2) mem_q[tail_p1] <= in_instr2;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_RUN;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (flush) begin
         state_q <= ST_RUN;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_q + PTR_W'(deq_n);
         tail_q  <= tail_q + PTR_W'(enq_n);
         count_q <= count_d;
         case (state_q)
            ST_RUN:         if (n1 && is_serial(head_w)) state_q <= ST_WAIT_SERIAL;
            ST_WAIT_SERIAL: if (serial_done) state_q <= ST_RUN;
            default:        state_q <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Bench for dispatch_scheduler: directed scenarios plus random traffic checked against a queue model.
module tb_dispatch_scheduler;

   localparam int DEPTH = 8;
   localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef PAIR_RAW_CHECK_EN
   localparam bit RAW_EN = 1'b1;
`else
   localparam bit RAW_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [31:0]      in_instr1 = '0, in_instr2 = '0;
   logic             in_valid1 = 1'b0, in_valid2 = 1'b0;
   logic             in_ready;
   logic [1:0]       be_slots = '0;
   logic             serial_done = 1'b0, flush = 1'b0;
   logic [31:0]      instruction1, instruction2;
   logic             ins1_valid, ins2_valid;
   logic [CNT_W-1:0] occupancy;
   logic             dbg_state_o;

   int total = 0;
   int bad   = 0;

   // Reference model: queued words in program order plus a "waiting for serial" flag.
   logic [31:0] exp_q[$];
   bit          m_wait = 1'b0;

   dispatch_scheduler #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_instr1(in_instr1), .in_instr2(in_instr2),
      .in_valid1(in_valid1), .in_valid2(in_valid2), .in_ready(in_ready),
      .be_slots(be_slots), .serial_done(serial_done), .flush(flush),
      .instruction1(instruction1), .instruction2(instruction2),
      .ins1_valid(ins1_valid), .ins2_valid(ins2_valid),
      .occupancy(occupancy), .dbg_state_o(dbg_state_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit is_ser(input logic [31:0] w);
      return (w[6:0] == 7'b1110011) || (w[6:0] == 7'b0001111);
   endfunction

   function automatic bit raw_hz(input logic [31:0] a, input logic [31:0] b);
      bit wr;
      wr = (a[11:7] != 0) && (a[6:0] != 7'b0100011) && (a[6:0] != 7'b1100011);
      return wr && ((a[11:7] == b[19:15]) || (a[11:7] == b[24:20]));
   endfunction

   // One cycle, entered and left at a falling edge.
   task automatic step(input logic v1, input logic [31:0] w1, input logic v2,
                       input logic [31:0] w2, input logic [1:0] be,
                       input logic sd, input logic fl);
      int  n, sl;
      bit  e1, e2, rdy;
      in_valid1 = v1; in_instr1 = w1; in_valid2 = v2; in_instr2 = w2;
      be_slots = be; serial_done = sd; flush = fl;
      #1;
      n   = exp_q.size();
      sl  = (be == 2'd3) ? 2 : int'(be);
      rdy = (DEPTH - n) >= 2;
      e1  = !fl && !m_wait && n >= 1 && sl >= 1;
      e2  = 1'b0;
      if (e1 && n >= 2 && sl >= 2)
         e2 = !is_ser(exp_q[0]) && !is_ser(exp_q[1]) && !(RAW_EN && raw_hz(exp_q[0], exp_q[1]));
      check("in_ready", 32'(in_ready), 32'(rdy));
      check("ins1_valid", 32'(ins1_valid), 32'(e1));
      check("ins2_valid", 32'(ins2_valid), 32'(e2));
      check("instruction1", instruction1, e1 ? exp_q[0] : 32'h0);
      check("instruction2", instruction2, e2 ? exp_q[1] : 32'h0);
      check("occupancy", 32'(occupancy), 32'(n));
      check("wait_state", 32'(dbg_state_o), 32'(m_wait));
      @(posedge clk);
      if (fl) begin
         exp_q.delete();
         m_wait = 1'b0;
      end else begin
         if (m_wait) begin
            if (sd) m_wait = 1'b0;
         end else if (e1 && is_ser(exp_q[0])) begin
            m_wait = 1'b1;
         end
         if (e1) void'(exp_q.pop_front());
         if (e2) void'(exp_q.pop_front());
         if (rdy && v1) begin
            exp_q.push_back(w1);
            if (v2) exp_q.push_back(w2);
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input logic [1:0] be, input logic sd);
      step(1'b0, 32'h0, 1'b0, 32'h0, be, sd, 1'b0);
   endtask

   // Asynchronous reset pulse landing between clock edges.
   task automatic do_reset();
      #1 rst = 1'b0;
      #1;
      exp_q.delete();
      m_wait = 1'b0;
      check("rst_occupancy", 32'(occupancy), 32'd0);
      check("rst_ins1_valid", 32'(ins1_valid), 32'd0);
      check("rst_ins2_valid", 32'(ins2_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_instruction1", instruction1, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom;
      w[11:7]  = 5'($urandom_range(0, 3));
      w[19:15] = 5'($urandom_range(0, 3));
      w[24:20] = 5'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
         0, 1:    w[6:0] = 7'b0010011;
         2, 3:    w[6:0] = 7'b0110011;
         4:       w[6:0] = 7'b1110011;
         5:       w[6:0] = 7'b0001111;
         6:       w[6:0] = 7'b0100011;
         default: w[6:0] = 7'b1100011;
      endcase
      return w;
   endfunction

   initial begin
      #2;
      check("por_occupancy", 32'(occupancy), 32'd0);
      check("por_ins1_valid", 32'(ins1_valid), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Simple pair in, both out next cycle.
      step(1'b1, 32'h00500093, 1'b1, 32'h00A00113, 2'd2, 1'b0, 1'b0);
      idle(2'd2, 1'b0);
      idle(2'd2, 1'b0);

      // Fill with no backend slots, then drain one per cycle across the wrap.
      for (int i = 0; i < 4; i++)
         step(1'b1, 32'h00000013 | (32'(2 * i) << 20), 1'b1,
              32'h00000013 | (32'(2 * i + 1) << 20), 2'd0, 1'b0, 1'b0);
      idle(2'd0, 1'b0);
      for (int i = 0; i < 9; i++) idle(2'd1, 1'b0);

      // ECALL serialises; ADDI waits for serial_done.
      step(1'b1, 32'h00000073, 1'b1, 32'h00100093, 2'd2, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) idle(2'd2, 1'b0);
      idle(2'd2, 1'b1);
      idle(2'd2, 1'b0);
      idle(2'd2, 1'b0);

      // Flush with six queued and an incoming word.
      for (int i = 0; i < 3; i++)
         step(1'b1, 32'h00200093 + 32'(i), 1'b1, 32'h00300113 + 32'(i), 2'd0, 1'b0, 1'b0);
      step(1'b1, 32'h00700193, 1'b0, 32'h0, 2'd2, 1'b0, 1'b1);
      idle(2'd2, 1'b0);

      // Dependent pair.
      step(1'b1, 32'h00500093, 1'b1, 32'h00108133, 2'd2, 1'b0, 1'b0);
      idle(2'd2, 1'b0);
      idle(2'd2, 1'b0);
      idle(2'd2, 1'b0);

      // Reset mid-stream with five queued, then enqueue straight away.
      for (int i = 0; i < 2; i++)
         step(1'b1, 32'h00400093, 1'b1, 32'h00400113, 2'd0, 1'b0, 1'b0);
      step(1'b1, 32'h00400193, 1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
      do_reset();
      step(1'b1, 32'h00900093, 1'b1, 32'h00900113, 2'd0, 1'b0, 1'b0);
      idle(2'd3, 1'b0);
      idle(2'd3, 1'b0);

      // Random traffic.
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            step(1'($urandom_range(0, 2) != 0), rand_instr(), 1'($urandom_range(0, 1)),
                 rand_instr(), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 39) == 0));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
